// File: rtl/wm_ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | wm_ctrl_pkg : shared types, widths and helpers for wm_mul_arbiter        |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package wm_ctrl_pkg;

  localparam int WM_OP_W      = 32;
  localparam int WM_PROD_W    = 64;
  localparam int WM_MUL_OUT_W = 65;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } wm_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of the most negative value.
  function automatic logic [WM_OP_W-1:0] wm_mag(input logic [WM_OP_W-1:0] v);
    return v[WM_OP_W-1] ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wm_rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | wm_rr_arbiter : combinational round-robin picker starting at ptr         |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module wm_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wm_mul_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | wm_mul_arbiter : round-robin sequencer for a shared multicycle 32x32     |
// | multiplier. Optional signed support via WM_ARB_SIGNED_EN. Rev 1.0        |
// +-------------------------------------------------------------------------+
module wm_mul_arbiter
  import wm_ctrl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WM_OP_W-1:0]   req_a,
  input  logic [NREQ*WM_OP_W-1:0]   req_b,
`ifdef WM_ARB_SIGNED_EN
  input  logic [NREQ-1:0]           req_signed,
`endif
  output logic [WM_OP_W-1:0]        mul_a,
  output logic [WM_OP_W-1:0]        mul_b,
  input  logic [WM_MUL_OUT_W-1:0]   mul_p,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [WM_PROD_W-1:0]      resp_prod,
  output logic                      busy
);

  localparam int              IW       = $clog2(NREQ);
  localparam int              CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

  wm_state_t            state;
  logic [IW-1:0]        ptr;
  logic [CW-1:0]        cnt;
  logic [NREQ-1:0]      grant;
  logic [IW-1:0]        grant_idx;
  logic                 grant_any;
  logic [WM_OP_W-1:0]   raw_a;
  logic [WM_OP_W-1:0]   raw_b;
  logic [WM_OP_W-1:0]   sel_a;
  logic [WM_OP_W-1:0]   sel_b;
  logic [WM_PROD_W-1:0] prod_next;
  logic                 unused_mul_msb;

  wm_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ready      = grant;
  assign unused_mul_msb = mul_p[WM_MUL_OUT_W-1];
  assign raw_a          = req_a[grant_idx*WM_OP_W +: WM_OP_W];
  assign raw_b          = req_b[grant_idx*WM_OP_W +: WM_OP_W];

`ifdef WM_ARB_SIGNED_EN
  logic sign_d;
  logic sign_q;

  // Multiply magnitudes and re-apply the sign when the product is captured.
  assign sign_d    = req_signed[grant_idx] & (raw_a[WM_OP_W-1] ^ raw_b[WM_OP_W-1]);
  assign sel_a     = req_signed[grant_idx] ? wm_mag(raw_a) : raw_a;
  assign sel_b     = req_signed[grant_idx] ? wm_mag(raw_b) : raw_b;
  assign prod_next = sign_q ? -mul_p[WM_PROD_W-1:0] : mul_p[WM_PROD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      sign_q <= sign_d;
    end
  end
`else
  assign sel_a     = raw_a;
  assign sel_b     = raw_b;
  assign prod_next = mul_p[WM_PROD_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_prod  <= '0;
      resp_id    <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            mul_a   <= sel_a;
            mul_b   <= sel_b;
            resp_id <= grant_idx;
            ptr     <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        // Operands are held stable here so the multiplier is a multicycle path.
        WAIT: begin
          if (cnt == '0) begin
            resp_prod  <= prod_next;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wm_mul_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | tb_wm_mul_arbiter : directed self-checking bench for wm_mul_arbiter      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_wm_mul_arbiter;

  localparam int NREQ       = 4;
  localparam int MUL_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
`ifdef WM_ARB_SIGNED_EN
  logic [3:0]   req_signed;
`endif
  logic [31:0]  mul_a;
  logic [31:0]  mul_b;
  logic [64:0]  mul_p;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [63:0]  resp_prod;
  logic         busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // External multiplier model; bit 64 set to show it is ignored.
  assign mul_p = {1'b1, {32'd0, mul_a} * {32'd0, mul_b}};

  wm_mul_arbiter #(.NREQ(NREQ), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef WM_ARB_SIGNED_EN
    .req_signed (req_signed),
`endif
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
`ifdef WM_ARB_SIGNED_EN
    req_signed = '0;
`endif
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({busy, resp_valid, resp_id, resp_prod, mul_a, mul_b, req_ready} !== '0)
      $display("FAIL reset_state: busy=%b rv=%b id=%0d prod=%h a=%h b=%h rdy=%b (want all 0)",
               busy, resp_valid, resp_id, resp_prod, mul_a, mul_b, req_ready);
    else passed++;
  endtask

  task automatic test_single;
    do_reset;
    req_a[31:0] = 32'd3;
    req_b[31:0] = 32'd5;
    req_valid   = 4'b0001;
    resp_ready  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready);
    else passed++;
    tick;
    req_valid = '0;
    checks++;
    if ({busy, resp_valid, mul_a, mul_b} !== {1'b1, 1'b0, 32'd3, 32'd5})
      $display("FAIL single_latch: busy=%b rv=%b a=%0d b=%0d want 1 0 3 5", busy, resp_valid, mul_a, mul_b);
    else passed++;
    tick;
    checks++;
    if (resp_valid !== 1'b0) $display("FAIL single_early: resp_valid=%b want 0 at T+1", resp_valid);
    else passed++;
    tick;
    checks++;
    if ({resp_valid, resp_id, resp_prod} !== {1'b1, 2'd0, 64'd15})
      $display("FAIL single_resp: rv=%b id=%0d prod=%0d want 1 0 15", resp_valid, resp_id, resp_prod);
    else passed++;
    tick;
    checks++;
    if ({resp_valid, busy} !== 2'b00) $display("FAIL single_release: rv=%b busy=%b want 0 0", resp_valid, busy);
    else passed++;
  endtask

  task automatic test_max;
    bit got = 0;
    do_reset;
    req_a[127:96] = 32'hFFFF_FFFF;
    req_b[127:96] = 32'hFFFF_FFFF;
    req_valid     = 4'b1000;
    resp_ready    = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) $display("FAIL max_ready: got %b want 1000", req_ready);
    else passed++;
    tick;
    req_valid = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (resp_valid) got = 1;
    end
    checks++;
    if (!got) $display("FAIL max_timeout: no resp_valid within 10 cycles");
    else if ({resp_id, resp_prod} !== {2'd3, 64'hFFFF_FFFE_0000_0001})
      $display("FAIL max_resp: id=%0d prod=%h want 3 fffffffe00000001", resp_id, resp_prod);
    else passed++;
  endtask

  task automatic test_fairness;
    logic [1:0]  exp_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [63:0] exp_prod [5] = '{64'd14, 64'd21, 64'd28, 64'd35, 64'd14};
    logic [1:0]  got_id   [5];
    logic [63:0] got_prod [5];
    int          got_cyc  [5];
    int n = 0;
    int viol = 0;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'(i + 2);
      req_b[32*i +: 32] = 32'd7;
    end
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 60 && n < 5; c++) begin
      if ($countones(req_ready) > 1) viol++;
      if (resp_valid) begin
        got_id[n]   = resp_id;
        got_prod[n] = resp_prod;
        got_cyc[n]  = c;
        n++;
      end
      tick;
    end
    req_valid = '0;
    checks++;
    if (n !== 5) $display("FAIL fair_count: got %0d responses want 5", n);
    else passed++;
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_id[k], got_prod[k]} !== {exp_id[k], exp_prod[k]})
        $display("FAIL fair_resp%0d: id=%0d prod=%0d want id=%0d prod=%0d",
                 k, got_id[k], got_prod[k], exp_id[k], exp_prod[k]);
      else passed++;
    end
    checks++;
    if (viol !== 0) $display("FAIL fair_onehot: %0d cycles with >1 req_ready want 0", viol);
    else passed++;
    if (n == 5) begin
      checks++;
      if (got_cyc[4] - got_cyc[0] !== 4 * (MUL_CYCLES + 2))
        $display("FAIL fair_throughput: span %0d cycles want %0d", got_cyc[4] - got_cyc[0], 4 * (MUL_CYCLES + 2));
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    bit got = 0;
    do_reset;
    req_a[95:64] = 32'h1234;
    req_b[95:64] = 32'h10;
    req_valid    = 4'b0100;
    resp_ready   = 1'b0;
    #1;
    tick;
    req_valid = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (resp_valid) got = 1;
    end
    checks++;
    if (!got) $display("FAIL bp_timeout: no resp_valid within 10 cycles");
    else passed++;
    req_valid = 4'b1011;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({resp_valid, resp_id, resp_prod, req_ready, busy} !== {1'b1, 2'd2, 64'h12340, 4'b0000, 1'b1})
        $display("FAIL bp_hold%0d: rv=%b id=%0d prod=%h rdy=%b busy=%b want 1 2 12340 0000 1",
                 c, resp_valid, resp_id, resp_prod, req_ready, busy);
      else passed++;
      tick;
    end
    resp_ready = 1'b1;
    tick;
    checks++;
    if ({resp_valid, req_ready} !== {1'b0, 4'b1000})
      $display("FAIL bp_release: rv=%b rdy=%b want 0 1000", resp_valid, req_ready);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_reset_mid_wait;
    bit seen = 0;
    do_reset;
    req_a[63:32] = 32'd7;
    req_b[63:32] = 32'd7;
    req_valid    = 4'b0010;
    resp_ready   = 1'b1;
    #1;
    tick;
    req_valid = '0;
    checks++;
    if ({busy, resp_id, mul_a} !== {1'b1, 2'd1, 32'd7})
      $display("FAIL abort_pre: busy=%b id=%0d a=%0d want 1 1 7", busy, resp_id, mul_a);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, resp_valid, resp_id, resp_prod, mul_a, mul_b, req_ready} !== '0)
      $display("FAIL abort_clear: busy=%b rv=%b id=%0d prod=%h a=%h b=%h rdy=%b want all 0",
               busy, resp_valid, resp_id, resp_prod, mul_a, mul_b, req_ready);
    else passed++;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (resp_valid || busy) seen = 1;
    end
    checks++;
    if (seen) $display("FAIL abort_noresp: activity after aborted op, got 1 want 0");
    else passed++;
  endtask

  task automatic test_wrap;
    bit got = 0;
    do_reset;
    req_a[95:64] = 32'd2;
    req_b[95:64] = 32'd9;
    req_valid    = 4'b0100;
    resp_ready   = 1'b1;
    #1;
    tick;
    req_valid = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (resp_valid) got = 1;
    end
    checks++;
    if (!got) $display("FAIL wrap_timeout: no resp_valid within 10 cycles");
    else if ({resp_id, resp_prod} !== {2'd2, 64'd18})
      $display("FAIL wrap_resp: id=%0d prod=%0d want 2 18", resp_id, resp_prod);
    else passed++;
    tick;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL wrap_grant: rdy=%b want 0001", req_ready);
    else passed++;
    req_valid = '0;
    tick;
    tick;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) $display("FAIL ptr_hold: rdy=%b want 1000", req_ready);
    else passed++;
    req_valid = '0;
  endtask

`ifdef WM_ARB_SIGNED_EN
  task automatic test_signed;
    logic [31:0] va [2] = '{32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] vb [2] = '{32'd6,         32'h8000_0000};
    logic [63:0] ve [2] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000};
    for (int t = 0; t < 2; t++) begin
      bit got = 0;
      do_reset;
      req_a[31:0]   = va[t];
      req_b[31:0]   = vb[t];
      req_signed    = 4'b0001;
      req_valid     = 4'b0001;
      resp_ready    = 1'b1;
      #1;
      tick;
      req_valid = '0;
      for (int i = 0; i < 10 && !got; i++) begin
        tick;
        if (resp_valid) got = 1;
      end
      checks++;
      if (!got) $display("FAIL signed%0d_timeout: no resp_valid", t);
      else if (resp_prod !== ve[t])
        $display("FAIL signed%0d: prod=%h want %h", t, resp_prod, ve[t]);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_max;
    test_fairness;
    test_backpressure;
    test_reset_mid_wait;
    test_wrap;
`ifdef WM_ARB_SIGNED_EN
    test_signed;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/wm_mul_arbiter.md
# wm_mul_arbiter

Sequencing and sharing controller for the 32x32 Wallace-tree multiplier datapath. It accepts multiply requests from `NREQ` requesters and grants one at a time in round-robin order. It drives registered operands into one shared multiplier instance and holds them for `MUL_CYCLES` clock cycles, so the multiplier runs as a multicycle path. It then captures the 64-bit product and returns it with the requester ID over a valid/ready response channel.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `MUL_CYCLES`, 2: cycles operands are held before the product is sampled (>=1).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`  in  NREQ*32  operand A, requester i at `[32*i+:32]`.
- `req_b`  in  NREQ*32  operand B, same packing.
- `req_signed`  in  NREQ  signed-operation flag; present only with `WM_ARB_SIGNED_EN`.
- `mul_a`  out  32  registered operand A to multiplier.
- `mul_b`  out  32  registered operand B to multiplier.
- `mul_p`  in  65  multiplier result; bits [63:0] used, bit 64 ignored.
- `resp_valid`  out  1  product available.
- `resp_ready`  in  1  consumer accepts product.
- `resp_id`  out  $clog2(NREQ)  index of the requester that owns the product.
- `resp_prod`  out  64  product.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: round-robin search starts at pointer `ptr`. The first requester with `req_valid` wins and gets `req_ready[w]=1`. This is combinational, only in IDLE, and only for the winner.
- On the handshake edge:
  - Latch operands into `mul_a`/`mul_b` and `w` into `resp_id`.
  - Set `ptr = (w+1) mod NREQ`.
  - Load counter with `MUL_CYCLES-1` and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, register `mul_p[63:0]` into `resp_prod` and go to DONE.
- DONE: `resp_valid=1`. `resp_prod` and `resp_id` stay stable until `resp_valid & resp_ready`, then return to IDLE.
- No grant is issued in DONE, so there is no overlap between operations.
- Requesters hold `req_valid` and operands until their `req_ready`. The block does not require this of requesters that are not granted.
- A requester that drops `req_valid` before grant is skipped. `ptr` does not move without a grant.
- `mul_a`/`mul_b` hold their last value outside WAIT.

## Timing
- Reset values (async, immediate):
  - state=IDLE, `ptr`=0, counter=0.
  - `mul_a`=`mul_b`=0, `resp_prod`=0, `resp_id`=0.
  - `resp_valid`=0, `busy`=0, `req_ready`=0.
- Reset in WAIT or DONE aborts the operation and discards the result. No response is issued for it.
- Latency: the handshake is at edge T, `resp_valid` rises after edge T+`MUL_CYCLES`, giving `MUL_CYCLES` cycles of operand settling.
- Throughput with `resp_ready` tied high: one product per `MUL_CYCLES`+2 cycles.
- With `MUL_CYCLES`=1, WAIT lasts exactly one cycle.
- Arbitration is fair: with all requesters continuously valid, grants go 0,1,…,NREQ-1,0,…
- Output `req_ready` depends combinationally on `req_valid` and state.

## Configuration
- `WM_ARB_SIGNED_EN` defined:
  - The `req_signed` port exists.
  - For a signed request, the operands are replaced by their two's-complement magnitudes before latching. The magnitude of 0x80000000 is 0x80000000.
  - The sign `sa^sb` is registered. In WAIT→DONE, `resp_prod` = sign ? -mul_p[63:0] : mul_p[63:0].
- `WM_ARB_SIGNED_EN` undefined: no `req_signed` port, all operations are unsigned, and there is no negation logic.

## Structure
- Package `wm_ctrl_pkg`:
  - state enum (IDLE, WAIT, DONE);
  - `WM_OP_W`=32, `WM_PROD_W`=64, `WM_MUL_OUT_W`=65.
- Sub-module `wm_rr_arbiter`: parameterised by `NREQ`; inputs `req`, `ptr`, `en`; outputs `grant` (one-hot), `grant_idx`, `any`. It is purely combinational.
- The FSM, counter, operand/result registers and sign logic live in `wm_mul_arbiter`. The multiplier is instantiated outside it.

## Test plan
- Reset: assert `rst_n`=0 mid-WAIT → all outputs 0 at once. After release, no `resp_valid` appears for the aborted request.
- Single request, `MUL_CYCLES`=2: requester 0 sends a=3, b=5 → `resp_valid` two cycles after the handshake, with `resp_prod`=15, `resp_id`=0.
- Maximum value: a=b=0xFFFF_FFFF → `resp_prod`=0xFFFF_FFFE_0000_0001.
- Fairness: all four requesters continuously valid, `resp_ready`=1 → `resp_id` sequence 0,1,2,3,0. At most one `req_ready` bit is high in any cycle.
- Backpressure: `resp_ready`=0 for 10 cycles in DONE → `resp_valid`, `resp_prod` and `resp_id` stable, `req_ready`=0, `busy`=1.
- Signed (`WM_ARB_SIGNED_EN`):
  - a=0xFFFF_FFF9, b=6, signed → 0xFFFF_FFFF_FFFF_FFD6.
  - a=b=0x8000_0000, signed → 0x4000_0000_0000_0000.
